// File: rtl/cache_controller.sv
// Direct-mapped write-back cache controller: a CPU-side request FSM that
// looks up a line, writes back a dirty victim, allocates from memory and
// fills the line. The optional hit/miss statistics counters are enabled by
// defining CACHE_STATS_EN.
module cache_controller #(
  parameter int unsigned INDEX_W = 6,
  parameter int unsigned TAG_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  // CPU side
  input  logic             cpu_req,
  input  logic             cpu_we,
  input  logic [31:0]      cpu_addr,
  input  logic [31:0]      cpu_wdata,
  output logic             cpu_ready,
  output logic [31:0]      cpu_rdata,
  // Cache array side
  input  logic             cache_hit,
  input  logic             cache_dirty,
  input  logic [31:0]      cache_rdata,
  input  logic [TAG_W-1:0] cache_tag,
  output logic             we_cache,
  output logic             set_valid,
  output logic             set_dirty,
  output logic [31:0]      cache_addr,
  output logic [31:0]      cache_wdata,
  // Backing memory side
  output logic             mem_req,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ack
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]      hit_count,
  output logic [31:0]      miss_count
`endif
);

  localparam int unsigned AW = INDEX_W + TAG_W;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMPARE   = 3'd1,
    WRITEBACK = 3'd2,
    ALLOCATE  = 3'd3,
    FILL      = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               we_q, we_d;
  logic [AW-1:0]      addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [TAG_W-1:0]   wb_tag_q, wb_tag_d;
  logic [31:0]        wb_data_q, wb_data_d;
  logic [31:0]        fill_data_q, fill_data_d;

  logic               cpu_ready_q, cpu_ready_d;
  logic [31:0]        cpu_rdata_q, cpu_rdata_d;
  logic               we_cache_q, we_cache_d;
  logic               set_valid_q, set_valid_d;
  logic               set_dirty_q, set_dirty_d;
  logic [31:0]        cache_addr_q, cache_addr_d;
  logic [31:0]        cache_wdata_q, cache_wdata_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        mem_wdata_q, mem_wdata_d;
  logic               hit_inc, miss_inc;

  // Upper address bits carry no tag or index information.
  logic unused_addr;
  assign unused_addr = ^cpu_addr[31:AW];

  // Next-state, capture registers and registered-output values.
  always_comb begin
    state_d       = state_q;
    we_d          = we_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wb_tag_d      = wb_tag_q;
    wb_data_d     = wb_data_q;
    fill_data_d   = fill_data_q;
    cpu_ready_d   = 1'b0;
    cpu_rdata_d   = 32'd0;
    we_cache_d    = 1'b0;
    set_valid_d   = 1'b0;
    set_dirty_d   = 1'b0;
    cache_wdata_d = 32'd0;
    hit_inc       = 1'b0;
    miss_inc      = 1'b0;
    // The address shown to the array belongs to the state being left, so a
    // registered write strobe always lines up with the latched address.
    cache_addr_d  = (state_q == IDLE) ? 32'(cpu_addr[AW-1:0]) : 32'(addr_q);

    case (state_q)
      IDLE: begin
        if (cpu_req && !cpu_ready_q) begin
          we_d    = cpu_we;
          addr_d  = cpu_addr[AW-1:0];
          wdata_d = cpu_wdata;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        if (cache_hit) begin
          hit_inc     = 1'b1;
          cpu_ready_d = 1'b1;
          if (we_q) begin
            we_cache_d    = 1'b1;
            set_valid_d   = 1'b1;
            set_dirty_d   = 1'b1;
            cache_wdata_d = wdata_q;
          end else begin
            cpu_rdata_d = cache_rdata;
          end
          state_d = IDLE;
        end else begin
          miss_inc = 1'b1;
          if (cache_dirty) begin
            wb_tag_d  = cache_tag;
            wb_data_d = cache_rdata;
            state_d   = WRITEBACK;
          end else begin
            state_d = ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        if (mem_ack) state_d = ALLOCATE;
      end
      ALLOCATE: begin
        if (mem_ack) begin
          fill_data_d = mem_rdata;
          state_d     = FILL;
        end
      end
      FILL: begin
        we_cache_d    = 1'b1;
        set_valid_d   = 1'b1;
        set_dirty_d   = we_q;
        cache_wdata_d = we_q ? wdata_q : fill_data_q;
        cpu_ready_d   = 1'b1;
        cpu_rdata_d   = fill_data_q;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Memory request follows the state being entered, so it is stable for
    // the whole transaction and drops in the cycle after the final ack.
    mem_req_d   = (state_d == WRITEBACK) || (state_d == ALLOCATE);
    mem_we_d    = (state_d == WRITEBACK);
    mem_addr_d  = 32'd0;
    mem_wdata_d = 32'd0;
    if (state_d == WRITEBACK) begin
      mem_addr_d  = 32'({wb_tag_d, addr_q[INDEX_W-1:0]});
      mem_wdata_d = wb_data_d;
    end else if (state_d == ALLOCATE) begin
      mem_addr_d  = 32'(addr_q);
    end
  end

  // State, capture and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      we_q          <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= 32'd0;
      wb_tag_q      <= '0;
      wb_data_q     <= 32'd0;
      fill_data_q   <= 32'd0;
      cpu_ready_q   <= 1'b0;
      cpu_rdata_q   <= 32'd0;
      we_cache_q    <= 1'b0;
      set_valid_q   <= 1'b0;
      set_dirty_q   <= 1'b0;
      cache_addr_q  <= 32'd0;
      cache_wdata_q <= 32'd0;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= 32'd0;
      mem_wdata_q   <= 32'd0;
    end else begin
      state_q       <= state_d;
      we_q          <= we_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wb_tag_q      <= wb_tag_d;
      wb_data_q     <= wb_data_d;
      fill_data_q   <= fill_data_d;
      cpu_ready_q   <= cpu_ready_d;
      cpu_rdata_q   <= cpu_rdata_d;
      we_cache_q    <= we_cache_d;
      set_valid_q   <= set_valid_d;
      set_dirty_q   <= set_dirty_d;
      cache_addr_q  <= cache_addr_d;
      cache_wdata_q <= cache_wdata_d;
      mem_req_q     <= mem_req_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
    end
  end

  assign cpu_ready   = cpu_ready_q;
  assign cpu_rdata   = cpu_rdata_q;
  assign we_cache    = we_cache_q;
  assign set_valid   = set_valid_q;
  assign set_dirty   = set_dirty_q;
  assign cache_addr  = cache_addr_q;
  assign cache_wdata = cache_wdata_q;
  assign mem_req     = mem_req_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;

`ifdef CACHE_STATS_EN
  logic [31:0] hit_cnt_q, hit_cnt_d;
  logic [31:0] miss_cnt_q, miss_cnt_d;

  // Free-running hit/miss counters, wrapping naturally at 32 bits.
  always_comb begin
    hit_cnt_d  = hit_inc  ? hit_cnt_q  + 32'd1 : hit_cnt_q;
    miss_cnt_d = miss_inc ? miss_cnt_q + 32'd1 : miss_cnt_q;
  end

  // Counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= 32'd0;
      miss_cnt_q <= 32'd0;
    end else begin
      hit_cnt_q  <= hit_cnt_d;
      miss_cnt_q <= miss_cnt_d;
    end
  end

  assign hit_count  = hit_cnt_q;
  assign miss_count = miss_cnt_q;
`else
  // Lookup outcome only feeds the statistics counters.
  logic unused_stats;
  assign unused_stats = hit_inc ^ miss_inc;
`endif

endmodule

// File: tb/tb_cache_controller.sv
// Directed bench for cache_controller: a behavioural cache array and a
// memory responder with programmable ack delay around the DUT.
module tb_cache_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_req, cpu_we;
  logic [31:0] cpu_addr, cpu_wdata;
  logic        cpu_ready;
  logic [31:0] cpu_rdata;
  logic        cache_hit, cache_dirty;
  logic [31:0] cache_rdata;
  logic [9:0]  cache_tag;
  logic        we_cache, set_valid, set_dirty;
  logic [31:0] cache_addr, cache_wdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_ack;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  cache_controller dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .cpu_req    (cpu_req),
    .cpu_we     (cpu_we),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_ready  (cpu_ready),
    .cpu_rdata  (cpu_rdata),
    .cache_hit  (cache_hit),
    .cache_dirty(cache_dirty),
    .cache_rdata(cache_rdata),
    .cache_tag  (cache_tag),
    .we_cache   (we_cache),
    .set_valid  (set_valid),
    .set_dirty  (set_dirty),
    .cache_addr (cache_addr),
    .cache_wdata(cache_wdata),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
`ifdef CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  // Behavioural direct-mapped array: 64 lines, 10-bit tags.
  logic        mv   [64];
  logic        md   [64];
  logic [9:0]  mt   [64];
  logic [31:0] mdat [64];
  logic [5:0]  c_idx;
  logic [9:0]  c_tag;
  logic        pl_clr, pl_en, pl_dirty;
  logic [5:0]  pl_idx;
  logic [9:0]  pl_tag;
  logic [31:0] pl_data;

  assign c_idx       = cache_addr[5:0];
  assign c_tag       = cache_addr[15:6];
  assign cache_hit   = mv[c_idx] && (mt[c_idx] == c_tag);
  assign cache_dirty = mv[c_idx] && md[c_idx];
  assign cache_rdata = mdat[c_idx];
  assign cache_tag   = mt[c_idx];

  always @(posedge clk) begin
    if (pl_clr) begin
      for (int i = 0; i < 64; i++) begin
        mv[i] <= 1'b0; md[i] <= 1'b0; mt[i] <= '0; mdat[i] <= '0;
      end
    end else if (pl_en) begin
      mv[pl_idx] <= 1'b1; md[pl_idx] <= pl_dirty;
      mt[pl_idx] <= pl_tag; mdat[pl_idx] <= pl_data;
    end else if (we_cache) begin
      mv[c_idx] <= set_valid; md[c_idx] <= set_dirty;
      mt[c_idx] <= c_tag; mdat[c_idx] <= cache_wdata;
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic preload(input logic [5:0] idx, input logic [9:0] tag,
                         input logic [31:0] data, input logic dirty);
    @(negedge clk);
    pl_en = 1'b1; pl_idx = idx; pl_tag = tag; pl_data = data; pl_dirty = dirty;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // Observations of the most recent access.
  int          r_cycles;
  logic        r_done, r_mem_seen, r_wb_seen, r_al_seen, r_wr_seen;
  logic [31:0] r_rdata, r_wb_addr, r_wb_data, r_al_addr, r_wr_data;
  logic        r_wr_dirty, r_wr_valid;

  task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input int ack_dly, input logic [31:0] rd);
    int cnt;
    cnt = 0;
    r_cycles = 0; r_done = 0; r_mem_seen = 0; r_wb_seen = 0; r_al_seen = 0; r_wr_seen = 0;
    r_rdata = '0; r_wb_addr = '0; r_wb_data = '0; r_al_addr = '0; r_wr_data = '0;
    r_wr_dirty = 0; r_wr_valid = 0;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 1; c <= 60 && !r_done; c++) begin
      @(negedge clk);
      if (mem_req) begin
        r_mem_seen = 1'b1;
        if (mem_we && !r_wb_seen) begin
          r_wb_seen = 1'b1; r_wb_addr = mem_addr; r_wb_data = mem_wdata;
        end
        if (!mem_we && !r_al_seen) begin
          r_al_seen = 1'b1; r_al_addr = mem_addr;
        end
      end
      if (we_cache) begin
        r_wr_seen = 1'b1; r_wr_data = cache_wdata; r_wr_dirty = set_dirty; r_wr_valid = set_valid;
      end
      if (cpu_ready) begin
        r_done = 1'b1; r_cycles = c; r_rdata = cpu_rdata; cpu_req = 1'b0;
      end
      if (mem_ack) begin
        mem_ack = 1'b0; cnt = 0;
      end else if (mem_req) begin
        cnt++;
        if (cnt >= ack_dly) begin
          mem_ack = 1'b1; mem_rdata = mem_we ? 32'h0 : rd;
        end
      end
    end
    cpu_req = 1'b0;
    mem_ack = 1'b0;
    check("access_done", 32'(r_done), 32'd1);
    @(negedge clk);
    check("ready_pulse", 32'(cpu_ready), 32'd0);
  endtask

  initial begin
    logic found;
    rst_n = 1'b0;
    cpu_req = 0; cpu_we = 0; cpu_addr = '0; cpu_wdata = '0;
    mem_ack = 0; mem_rdata = '0;
    pl_clr = 1'b1; pl_en = 1'b0; pl_dirty = 0; pl_idx = '0; pl_tag = '0; pl_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    pl_clr = 1'b0;

    // Reset state
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_we_cache", 32'(we_cache), 32'd0);
    check("rst_cache_addr", cache_addr, 32'd0);
    rst_n = 1'b1;

    // Read hit: line 5, tag 3 -> addr 0xC5
    preload(6'd5, 10'd3, 32'hDEADBEEF, 1'b0);
    access(1'b0, 32'h0000_00C5, 32'h0, 3, 32'h0);
    check("rh_cycles", r_cycles, 32'd2);
    check("rh_rdata", r_rdata, 32'hDEADBEEF);
    check("rh_no_mem", 32'(r_mem_seen), 32'd0);
    check("rh_no_write", 32'(r_wr_seen), 32'd0);

    // Clean read miss: line 7 invalid, ack after 3 cycles
    access(1'b0, 32'h0000_0047, 32'h0, 3, 32'h12345678);
    check("rm_no_wb", 32'(r_wb_seen), 32'd0);
    check("rm_alloc_addr", r_al_addr, 32'h47);
    check("rm_fill_data", r_wr_data, 32'h12345678);
    check("rm_fill_dirty", 32'(r_wr_dirty), 32'd0);
    check("rm_fill_valid", 32'(r_wr_valid), 32'd1);
    check("rm_rdata", r_rdata, 32'h12345678);

    // Dirty write miss: line 2 tag 1 dirty, write to 0x82 (tag 2)
    preload(6'd2, 10'd1, 32'hAAAA0000, 1'b1);
    access(1'b1, 32'h0000_0082, 32'h55, 2, 32'h0BADF00D);
    check("wm_wb_addr", r_wb_addr, 32'h42);
    check("wm_wb_data", r_wb_data, 32'hAAAA0000);
    check("wm_alloc_addr", r_al_addr, 32'h82);
    check("wm_fill_data", r_wr_data, 32'h55);
    check("wm_fill_dirty", 32'(r_wr_dirty), 32'd1);
    check("wm_rdata", r_rdata, 32'h0BADF00D);

    // Write hit on clean valid line 5
    access(1'b1, 32'h0000_00C5, 32'h1, 3, 32'h0);
    check("wh_cycles", r_cycles, 32'd2);
    check("wh_we", 32'(r_wr_seen), 32'd1);
    check("wh_dirty", 32'(r_wr_dirty), 32'd1);
    check("wh_wdata", r_wr_data, 32'h1);
    check("wh_no_mem", 32'(r_mem_seen), 32'd0);
    check("wh_rdata", r_rdata, 32'h0);

    // Read hit on the line filled by the earlier miss
    access(1'b0, 32'h0000_0047, 32'h0, 3, 32'h0);
    check("rh2_rdata", r_rdata, 32'h12345678);
    check("rh2_no_mem", 32'(r_mem_seen), 32'd0);

`ifdef CACHE_STATS_EN
    check("hit_count", hit_count, 32'd3);
    check("miss_count", miss_count, 32'd2);
`endif

    // Reset during ALLOCATE with no ack
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h48;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      if (mem_req && !mem_we) found = 1'b1;
    end
    check("ra_reached", 32'(found), 32'd1);
    check("ra_alloc_addr", mem_addr, 32'h48);
    #2 rst_n = 1'b0;
    #1;
    check("ra_mem_req", 32'(mem_req), 32'd0);
    check("ra_state", 32'(dut.state_q), 32'd0);
    check("ra_cpu_ready", 32'(cpu_ready), 32'd0);
`ifdef CACHE_STATS_EN
    check("ra_hit_count", hit_count, 32'd0);
`endif
    cpu_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Normal operation after reset: line 5 now holds 0x1 from the write hit
    access(1'b0, 32'h0000_00C5, 32'h0, 3, 32'h0);
    check("pr_cycles", r_cycles, 32'd2);
    check("pr_rdata", r_rdata, 32'h1);
    check("pr_no_mem", 32'(r_mem_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
